pi1_arb: RTL
============

PI1_ARB -- requirements
Module: pi1_arb

Interface
REQ-001 SHALL have parameter MASTERCOUNT, default 2, number of PI1 masters (legal 1..16).
REQ-002 SHALL have parameter ARCHBITSZ, default 32, data width (legal 16/32/64); ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
REQ-003 SHALL have parameter ARBMODE, default 0, arbitration policy: 0 round-robin, 1 fixed priority (lowest index wins).
REQ-004 SHALL have parameter MAXHOLD, default 4, accepted transactions per grant before forced release when contended; 0 means unlimited.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk_i  in  1  sole clock; all state on rising edge.
REQ-007 rst_i  in  1  asynchronous active-low reset.
REQ-008 m_op_i  in  2*MASTERCOUNT  per-master op (00 NOOP, 01 WR, 10 RD, 11 RW).
REQ-009 m_addr_i  in  ADDRBITSZ*MASTERCOUNT  per-master word address.
REQ-010 m_data_i  in  ARCHBITSZ*MASTERCOUNT  per-master write data.
REQ-011 m_sel_i  in  (ARCHBITSZ/8)*MASTERCOUNT  per-master byte selects.
REQ-012 m_data_o  out  ARCHBITSZ  read data broadcast to all masters.
REQ-013 m_rdy_o  out  MASTERCOUNT  per-master ready.
REQ-014 s_op_o / s_addr_o / s_data_o / s_sel_o  out  2 / ADDRBITSZ / ARCHBITSZ / ARCHBITSZ/8  slave-side request.
REQ-015 s_data_i  in  ARCHBITSZ  slave read data; s_rdy_i  in  1  slave ready.
REQ-016 gnt_o  out  MASTERCOUNT  one-hot registered grant (all-zero when idle).

Function
REQ-017 Transfer accepted in any cycle where s_op_o != NOOP and s_rdy_i = 1; read data valid on s_data_i that same cycle.
REQ-018 SHALL implement FSM IDLE, GRANT; reset state IDLE.
REQ-019 IDLE: s_op_o = NOOP, s_addr_o/s_data_o/s_sel_o = 0, m_rdy_o = 0; if any m_op_i != NOOP, register winner into gnt_o, clear holdcnt, go GRANT (1-cycle arbitration latency).
REQ-020 Round-robin: search starts at rrptr, wraps MASTERCOUNT-1 -> 0; on grant rrptr <= (winner+1) mod MASTERCOUNT.
REQ-021 Fixed priority: lowest requesting index wins; rrptr unused.
REQ-022 GRANT: s_op_o/s_addr_o/s_data_o/s_sel_o combinationally equal granted master's inputs; m_rdy_o[g] = s_rdy_i; all other m_rdy_o = 0.
REQ-023 m_data_o = s_data_i combinationally in all states.
REQ-024 holdcnt (clog2(MAXHOLD+1) bits, min 1) increments on each accepted transfer in GRANT; saturates, never wraps.
REQ-025 Release (GRANT -> IDLE next edge, gnt_o cleared) when granted m_op_i = NOOP, or when a transfer is accepted with holdcnt = MAXHOLD-1 (MAXHOLD != 0) and any other master has op != NOOP.
REQ-026 Uncontended master at MAXHOLD SHALL keep grant; holdcnt stays saturated.
REQ-027 Op changes by granted master between transfers SHALL pass through without re-arbitration.
REQ-028 MASTERCOUNT = 1: behaviour identical, gnt_o = 1 whenever in GRANT.
REQ-029 Request simultaneous with release cycle SHALL be arbitrated only in following IDLE cycle (min 1 NOOP cycle on slave between grants).

Reset
REQ-030 rst_i low SHALL immediately force IDLE, gnt_o = 0, rrptr = 0, holdcnt = 0, s_op_o = NOOP, m_rdy_o = 0, regardless of in-flight transfer.
REQ-031 After rst_i deasserts, first arbitration SHALL occur on the first rising edge with a pending request.

Verification
REQ-032 ARBMODE=0, N=2, both issue RD continuously, s_rdy_i=1, MAXHOLD=4 -> m0 gets 4 accepts, 1 idle cycle, m1 gets 4 accepts, alternating indefinitely.
REQ-033 ARBMODE=1, N=4, m1 and m3 request -> m1 granted; m3 granted only after m1 release; m0 arriving during m1 grant wins next arbitration over m3.
REQ-034 Only m2 requests, 10 WRs, s_rdy_i=1, MAXHOLD=4 -> gnt_o=0100 throughout, 10 accepts, no release.
REQ-035 m0 RD addr 0x100, s_rdy_i low 3 cycles then high with s_data_i=0xDEADBEEF -> m_rdy_o[0] high exactly 1 cycle, m_data_o=0xDEADBEEF; m_rdy_o[1]=0.
REQ-036 rst_i pulled low mid-GRANT with s_rdy_i=0 -> same-cycle s_op_o=NOOP, gnt_o=0; after release m0 and m1 request -> m0 granted (rrptr=0).
REQ-037 MAXHOLD=0, both request -> m0 holds until its op goes NOOP, then m1 granted after 1 idle cycle.

Source files
------------

// File: rtl/pi1_arb_if.sv
// -----------------------------------------------------------------------------
// pi1_arb_if -- bundle of every signal between a PI1 arbiter, its masters and
// the single downstream PI1 slave.
//
// Parameters
//   MASTERCOUNT  number of PI1 masters sharing the slave
//   ARCHBITSZ    data width (16/32/64); word address is ARCHBITSZ - log2(bytes)
//
// Signals (direction as seen by the arbiter)
//   m_op_i    in   2*MASTERCOUNT          per-master op (00 NOOP,01 WR,10 RD,11 RW)
//   m_addr_i  in   ADDRBITSZ*MASTERCOUNT  per-master word address
//   m_data_i  in   ARCHBITSZ*MASTERCOUNT  per-master write data
//   m_sel_i   in   SELBITSZ*MASTERCOUNT   per-master byte selects
//   m_data_o  out  ARCHBITSZ              read data broadcast to all masters
//   m_rdy_o   out  MASTERCOUNT            per-master ready
//   s_op_o / s_addr_o / s_data_o / s_sel_o  out  request towards the slave
//   s_data_i  in   ARCHBITSZ              slave read data
//   s_rdy_i   in   1                      slave ready
//   gnt_o     out  MASTERCOUNT            one-hot registered grant
//
// Modports
//   master  the arbiter itself: it masters the downstream slave bus
//   slave   the surroundings (masters plus slave device) facing the arbiter
// -----------------------------------------------------------------------------
interface pi1_arb_if #(
  parameter int MASTERCOUNT = 2,
  parameter int ARCHBITSZ   = 32
);
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);
  localparam int SELBITSZ  = ARCHBITSZ / 8;

  logic [2*MASTERCOUNT-1:0]         m_op_i;
  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i;
  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i;
  logic [SELBITSZ*MASTERCOUNT-1:0]  m_sel_i;
  logic [ARCHBITSZ-1:0]             m_data_o;
  logic [MASTERCOUNT-1:0]           m_rdy_o;

  logic [1:0]                       s_op_o;
  logic [ADDRBITSZ-1:0]             s_addr_o;
  logic [ARCHBITSZ-1:0]             s_data_o;
  logic [SELBITSZ-1:0]              s_sel_o;
  logic [ARCHBITSZ-1:0]             s_data_i;
  logic                             s_rdy_i;

  logic [MASTERCOUNT-1:0]           gnt_o;

  modport master (
    input  m_op_i, m_addr_i, m_data_i, m_sel_i, s_data_i, s_rdy_i,
    output m_data_o, m_rdy_o, s_op_o, s_addr_o, s_data_o, s_sel_o, gnt_o
  );

  modport slave (
    output m_op_i, m_addr_i, m_data_i, m_sel_i, s_data_i, s_rdy_i,
    input  m_data_o, m_rdy_o, s_op_o, s_addr_o, s_data_o, s_sel_o, gnt_o
  );
endinterface

// File: rtl/pi1_arb.sv
// -----------------------------------------------------------------------------
// pi1_arb -- N-to-1 PI1 bus arbiter.
//
// Any number of PI1 masters share one PI1 slave. While IDLE the arbiter picks
// one requesting master (round-robin or fixed priority) and registers it in
// gnt_o; in GRANT the winner's request is passed straight through to the slave
// and the slave's ready is routed back only to the winner. A grant is dropped
// when the winner goes NOOP, or, if MAXHOLD is non-zero and somebody else is
// waiting, after MAXHOLD accepted transfers. Every hand-over costs one IDLE
// cycle in which the slave sees NOOP.
//
// Parameters
//   MASTERCOUNT  1..16 masters
//   ARCHBITSZ    16/32/64 data width
//   ARBMODE      0 round-robin, 1 fixed priority (lowest index wins)
//   MAXHOLD      accepted transfers per grant before a contended release;
//                0 = hold until the winner goes NOOP
//
// Ports
//   clk_i   in  sole clock, rising edge
//   rst_i   in  asynchronous active-low reset
//   bus     pi1_arb_if.master -- all master- and slave-side PI1 signals
// -----------------------------------------------------------------------------
module pi1_arb #(
  parameter int MASTERCOUNT = 2,
  parameter int ARCHBITSZ   = 32,
  parameter int ARBMODE     = 0,
  parameter int MAXHOLD     = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  pi1_arb_if.master bus
);

  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8);
  localparam int SELBITSZ  = ARCHBITSZ / 8;
  localparam int IDXW      = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1;
  localparam int HOLDW     = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;
  // Saturation value of holdcnt, and the count at which the next accept is
  // the last one this grant may make under contention.
  localparam int HOLDSAT   = (MAXHOLD > 0) ? MAXHOLD : 1;
  localparam int HOLDLAST  = (MAXHOLD > 0) ? MAXHOLD - 1 : 0;

  localparam logic [1:0] OP_NOOP = 2'b00;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [MASTERCOUNT-1:0] gnt;
  logic [IDXW-1:0]   gidx;      // binary form of gnt, used for muxing
  logic [IDXW-1:0]   rrptr;
  logic [HOLDW-1:0]  holdcnt;

  logic [MASTERCOUNT-1:0] req;
  logic              any_req;
  logic              others_req;
  logic              winner_found;
  logic [IDXW-1:0]   winner;
  logic [1:0]        g_op;
  logic              accept;
  logic              grant_load;
  logic              release_gnt;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < MASTERCOUNT; i++) begin
      req[i] = (bus.m_op_i[2*i +: 2] != OP_NOOP);
    end
  end

  assign any_req    = |req;
  assign others_req = |(req & ~gnt);

  // ---------------------------------------------------------------------------
  // Winner search. Round-robin walks from rrptr upwards and wraps; fixed
  // priority always walks from index 0, so the same loop serves both.
  // ---------------------------------------------------------------------------
  always_comb begin : arb_search
    int cand;
    winner       = '0;
    winner_found = 1'b0;
    cand         = 0;
    for (int k = 0; k < MASTERCOUNT; k++) begin
      cand = (ARBMODE == 0) ? int'(rrptr) + k : k;
      if (cand >= MASTERCOUNT) begin
        cand = cand - MASTERCOUNT;
      end
      if (!winner_found && req[IDXW'(cand)]) begin
        winner_found = 1'b1;
        winner       = IDXW'(cand);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Granted master's request and the transfer-accept strobe
  // ---------------------------------------------------------------------------
  assign g_op   = bus.m_op_i[gidx*2 +: 2];
  assign accept = (state == GRANT) && (g_op != OP_NOOP) && bus.s_rdy_i;

  // Read data is broadcast unconditionally; only m_rdy_o qualifies it.
  assign bus.m_data_o = bus.s_data_i;
  assign bus.gnt_o    = gnt;

  // ---------------------------------------------------------------------------
  // FSM: next state and slave/master-side outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state   = state;
    grant_load   = 1'b0;
    release_gnt  = 1'b0;
    bus.s_op_o   = OP_NOOP;
    bus.s_addr_o = '0;
    bus.s_data_o = '0;
    bus.s_sel_o  = '0;
    bus.m_rdy_o  = '0;

    case (state)
      IDLE: begin
        if (any_req) begin
          grant_load = 1'b1;
          next_state = GRANT;
        end
      end

      GRANT: begin
        // Pure pass-through: op changes by the winner between transfers go
        // straight to the slave without re-arbitration.
        bus.s_op_o   = g_op;
        bus.s_addr_o = bus.m_addr_i[gidx*ADDRBITSZ +: ADDRBITSZ];
        bus.s_data_o = bus.m_data_i[gidx*ARCHBITSZ +: ARCHBITSZ];
        bus.s_sel_o  = bus.m_sel_i[gidx*SELBITSZ +: SELBITSZ];
        bus.m_rdy_o  = gnt & {MASTERCOUNT{bus.s_rdy_i}};

        if (g_op == OP_NOOP) begin
          release_gnt = 1'b1;
        end else if ((MAXHOLD != 0) && accept && others_req &&
                     (holdcnt >= HOLDW'(HOLDLAST))) begin
          // '>=' rather than '==' so a master that saturated while alone
          // still yields once someone else starts requesting.
          release_gnt = 1'b1;
        end

        if (release_gnt) begin
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: the reset is asynchronous, so it appears in the sensitivity list and
  // takes effect on its falling edge without waiting for clk_i; because the
  // slave-side outputs decode from state, they drop to NOOP at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant, round-robin pointer and hold counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking ones here would create ordering races.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gnt     <= '0;
      gidx    <= '0;
      rrptr   <= '0;
      holdcnt <= '0;
    end else if (grant_load) begin
      gnt     <= MASTERCOUNT'(1) << winner;
      gidx    <= winner;
      holdcnt <= '0;
      if (ARBMODE == 0) begin
        rrptr <= (int'(winner) == MASTERCOUNT - 1) ? '0 : winner + 1'b1;
      end
    end else if (release_gnt) begin
      gnt <= '0;
    end else if (accept && (holdcnt != HOLDW'(HOLDSAT))) begin
      holdcnt <= holdcnt + 1'b1;
    end
  end

endmodule
